calc_key_sequencer: RTL and testbench
=====================================

Name: calc_key_sequencer

Overview:
- Sequences the calculator flow between the IR key decoder and the 7-segment BCD decoders.
- Accepts decoded remote key codes with their valid strobe and builds signed 2-digit operands A and B plus the operator.
- Computes the signed result (magnitude 0..198) and drives the operand/result/sign signals consumed by the decoder99/decoder198 displays.
- Owns the state machine: entry of A, entry of B, calculation, result display.

Parameters:
- KEY_SIGN, 8'h0C, toggles the sign of the operand being entered
- KEY_PLUS, 8'h1A, selects addition
- KEY_MINUS, 8'h1E, selects subtraction
- KEY_ENTER, 8'h16, requests the calculation
- KEY_CLEAR, 8'h12, aborts and clears everything
- Digit keys are codes 8'h00..8'h09 and are not parameters.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- RESET_N  input  1  asynchronous active-low reset
- KEY_VALID  input  1  decoder "key received" level; may stay high many cycles
- KEY_CODE  input  8  decoded key code; stable while KEY_VALID high
- A  output  8  operand A magnitude, 0..99
- SIGN_A  output  1  1 = A negative
- B  output  8  operand B magnitude, 0..99
- SIGN_B  output  1  1 = B negative
- OP  output  1  0 = add, 1 = subtract
- RES  output  8  result magnitude, 0..198
- SIGN_R  output  1  1 = result negative
- RES_VALID  output  1  result on display is valid
- STATE  output  2  0 ENTRY_A, 1 ENTRY_B, 2 CALC, 3 SHOW

Behaviour:
- Reset (RESET_N low, asynchronous, also mid-operation):
  - All outputs 0.
  - STATE = ENTRY_A.
  - Digit counters cntA = cntB = 0.
  - Key-edge register kv_q = 0.
- Key event:
  - kv_q samples KEY_VALID every cycle.
  - event = KEY_VALID & ~kv_q; KEY_CODE is sampled at the same edge.
  - Exactly one event per KEY_VALID high period.
  - Effects are visible after the clock edge at which the event is detected (1-cycle latency).
- KEY_CLEAR in any state, including CALC: all outputs and counters return to reset values, STATE = ENTRY_A. CLEAR has highest priority.
- Codes not listed in this spec are ignored in every state.
- ENTRY_A:
  - Digit d: if cntA < 2, then A <= A*10 + d and cntA++. A third digit is ignored, so A never exceeds 99.
  - KEY_SIGN toggles SIGN_A. -0 is allowed for operands.
  - KEY_PLUS / KEY_MINUS: OP <= 0 / 1, STATE = ENTRY_B. This is accepted even when cntA = 0 (A = 0).
  - KEY_ENTER is ignored.
- ENTRY_B:
  - Digits update B and cntB with the same 2-digit rule.
  - KEY_SIGN toggles SIGN_B.
  - KEY_PLUS / KEY_MINUS overwrite OP and stay in ENTRY_B.
  - KEY_ENTER: STATE = CALC.
- CALC (exactly one cycle; key events in this cycle are consumed and ignored, except CLEAR):
  - sB = SIGN_B ^ OP.
  - If SIGN_A == sB: RES = A + B, SIGN_R = SIGN_A.
  - Else if A >= B: RES = A - B, SIGN_R = SIGN_A.
  - Else: RES = B - A, SIGN_R = sB.
  - If RES == 0, force SIGN_R = 0.
  - All arithmetic is unsigned 8-bit; no overflow is possible (max 198).
  - Set RES_VALID = 1, STATE = SHOW.
- SHOW:
  - RES, SIGN_R and RES_VALID are held; A, B, signs and OP stay displayed.
  - Digit d starts a new calculation: A <= d, cntA = 1, SIGN_A = 0, B = 0, SIGN_B = 0, cntB = 0, OP = 0, RES = 0, SIGN_R = 0, RES_VALID = 0, STATE = ENTRY_A.
  - KEY_SIGN, KEY_PLUS, KEY_MINUS and KEY_ENTER are ignored.
- Simultaneous events: only one key event can occur per cycle. Reset overrides everything asynchronously.

Test Plan:
- Reset, then KEY_VALID pulses 4, 2, PLUS, 1, 7, ENTER -> A=42, B=17, OP=0; after the CALC cycle, RES=59, SIGN_R=0, RES_VALID=1, STATE=3.
- Keys 1, 5, MINUS, 4, 0, ENTER -> RES=25, SIGN_R=1. Then digit 3 -> A=3, B=0, RES=0, RES_VALID=0, STATE=0.
- Keys 9, 9, 9, SIGN, MINUS, 9, 9, SIGN, MINUS(again), ENTER -> A=99, SIGN_A=1, B=99, SIGN_B=1, OP=1, RES=0, SIGN_R=0. Then CLEAR -> all zero. Then 9, 9, SIGN, PLUS, 9, 9, SIGN, ENTER -> RES=198, SIGN_R=1.
- KEY_VALID held high 1000 cycles with code 5 in ENTRY_A -> A=5 only (single event); a low gap then high again -> A=55.
- RESET_N pulsed low asynchronously mid-cycle while in ENTRY_B with A=12, B=3 -> outputs 0 immediately, without waiting for a clock edge; STATE=0.
- KEY_CLEAR arriving in the CALC cycle -> RES_VALID stays 0, STATE=0. Undefined code 8'h40 in each state -> no output change.

Source files
------------

// File: rtl/calc_key_sequencer.sv
// -----------------------------------------------------------------------------
// calc_key_sequencer
//
// Purpose:
//   Sits between the IR remote key decoder and the 7-segment BCD decoders of a
//   two-operand calculator. It turns key strobes into single key events, builds
//   the signed 2-digit operands A and B and the operator, computes the signed
//   result in a one-cycle CALC state, and holds everything for display.
//
// Ports:
//   CLOCK_50   in   1  system clock (50 MHz)
//   RESET_N    in   1  asynchronous active-low reset
//   KEY_VALID  in   1  "key received" level from the decoder (may stay high)
//   KEY_CODE   in   8  decoded key code, stable while KEY_VALID is high
//   A          out  8  operand A magnitude, 0..99
//   SIGN_A     out  1  1 = A negative
//   B          out  8  operand B magnitude, 0..99
//   SIGN_B     out  1  1 = B negative
//   OP         out  1  0 = add, 1 = subtract
//   RES        out  8  result magnitude, 0..198
//   SIGN_R     out  1  1 = result negative
//   RES_VALID  out  1  result on display is valid
//   STATE      out  2  0 ENTRY_A, 1 ENTRY_B, 2 CALC, 3 SHOW
// -----------------------------------------------------------------------------
module calc_key_sequencer #(
  parameter logic [7:0] KEY_SIGN  = 8'h0C,
  parameter logic [7:0] KEY_PLUS  = 8'h1A,
  parameter logic [7:0] KEY_MINUS = 8'h1E,
  parameter logic [7:0] KEY_ENTER = 8'h16,
  parameter logic [7:0] KEY_CLEAR = 8'h12
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       KEY_VALID,
  input  logic [7:0] KEY_CODE,
  output logic [7:0] A,
  output logic       SIGN_A,
  output logic [7:0] B,
  output logic       SIGN_B,
  output logic       OP,
  output logic [7:0] RES,
  output logic       SIGN_R,
  output logic       RES_VALID,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    ENTRY_A = 2'd0,
    ENTRY_B = 2'd1,
    CALC    = 2'd2,
    SHOW    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       kv_q, kv_d;
  logic [7:0] a_q, a_d;
  logic       sign_a_q, sign_a_d;
  logic [7:0] b_q, b_d;
  logic       sign_b_q, sign_b_d;
  logic       op_q, op_d;
  logic [7:0] res_q, res_d;
  logic       sign_r_q, sign_r_d;
  logic       res_valid_q, res_valid_d;
  logic [1:0] cnt_a_q, cnt_a_d;
  logic [1:0] cnt_b_q, cnt_b_d;

  logic       key_ev;
  logic       is_digit;
  logic [8:0] calc_out;

  // Shift one decimal digit into an operand. Only called while fewer than two
  // digits have been entered, so acc <= 9 and the result stays <= 99.
  function automatic logic [7:0] digit_append(input logic [7:0] acc,
                                              input logic [3:0] d);
    digit_append = acc * 8'd10 + {4'd0, d};
  endfunction

  // Signed add/subtract on sign-magnitude operands. Returns {sign, magnitude}.
  // Subtraction is folded into B's effective sign; zero is never negative.
  function automatic logic [8:0] calc_result(input logic [7:0] a,
                                             input logic       sa,
                                             input logic [7:0] b,
                                             input logic       sb_raw,
                                             input logic       op);
    logic       sb;
    logic [7:0] mag;
    logic       sgn;
    sb = sb_raw ^ op;
    if (sa == sb) begin
      mag = a + b;
      sgn = sa;
    end else if (a >= b) begin
      mag = a - b;
      sgn = sa;
    end else begin
      mag = b - a;
      sgn = sb;
    end
    if (mag == 8'd0) begin
      sgn = 1'b0;
    end
    calc_result = {sgn, mag};
  endfunction

  // One event per KEY_VALID high period: rising edge against last cycle's level.
  assign key_ev   = KEY_VALID & ~kv_q;
  assign is_digit = (KEY_CODE < 8'd10);
  assign calc_out = calc_result(a_q, sign_a_q, b_q, sign_b_q, op_q);
  assign kv_d     = KEY_VALID;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    sign_a_d    = sign_a_q;
    b_d         = b_q;
    sign_b_d    = sign_b_q;
    op_d        = op_q;
    res_d       = res_q;
    sign_r_d    = sign_r_q;
    res_valid_d = res_valid_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;

    if (key_ev && (KEY_CODE == KEY_CLEAR)) begin
      // CLEAR wins in every state, including the CALC cycle.
      state_d     = ENTRY_A;
      a_d         = 8'd0;
      sign_a_d    = 1'b0;
      b_d         = 8'd0;
      sign_b_d    = 1'b0;
      op_d        = 1'b0;
      res_d       = 8'd0;
      sign_r_d    = 1'b0;
      res_valid_d = 1'b0;
      cnt_a_d     = 2'd0;
      cnt_b_d     = 2'd0;
    end else begin
      unique case (state_q)
        ENTRY_A: begin
          if (key_ev) begin
            if (is_digit) begin
              if (cnt_a_q < 2'd2) begin
                a_d     = digit_append(a_q, KEY_CODE[3:0]);
                cnt_a_d = cnt_a_q + 2'd1;
              end
            end else if (KEY_CODE == KEY_SIGN) begin
              sign_a_d = ~sign_a_q;
            end else if (KEY_CODE == KEY_PLUS) begin
              op_d    = 1'b0;
              state_d = ENTRY_B;
            end else if (KEY_CODE == KEY_MINUS) begin
              op_d    = 1'b1;
              state_d = ENTRY_B;
            end
          end
        end

        ENTRY_B: begin
          if (key_ev) begin
            if (is_digit) begin
              if (cnt_b_q < 2'd2) begin
                b_d     = digit_append(b_q, KEY_CODE[3:0]);
                cnt_b_d = cnt_b_q + 2'd1;
              end
            end else if (KEY_CODE == KEY_SIGN) begin
              sign_b_d = ~sign_b_q;
            end else if (KEY_CODE == KEY_PLUS) begin
              op_d = 1'b0;
            end else if (KEY_CODE == KEY_MINUS) begin
              op_d = 1'b1;
            end else if (KEY_CODE == KEY_ENTER) begin
              state_d = CALC;
            end
          end
        end

        CALC: begin
          // Any non-CLEAR event landing here is swallowed.
          sign_r_d    = calc_out[8];
          res_d       = calc_out[7:0];
          res_valid_d = 1'b1;
          state_d     = SHOW;
        end

        SHOW: begin
          // A digit starts a fresh calculation with that digit as A's first.
          if (key_ev && is_digit) begin
            state_d     = ENTRY_A;
            a_d         = {4'd0, KEY_CODE[3:0]};
            cnt_a_d     = 2'd1;
            sign_a_d    = 1'b0;
            b_d         = 8'd0;
            sign_b_d    = 1'b0;
            cnt_b_d     = 2'd0;
            op_d        = 1'b0;
            res_d       = 8'd0;
            sign_r_d    = 1'b0;
            res_valid_d = 1'b0;
          end
        end

        default: state_d = ENTRY_A;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ENTRY_A;
      kv_q        <= 1'b0;
      a_q         <= 8'd0;
      sign_a_q    <= 1'b0;
      b_q         <= 8'd0;
      sign_b_q    <= 1'b0;
      op_q        <= 1'b0;
      res_q       <= 8'd0;
      sign_r_q    <= 1'b0;
      res_valid_q <= 1'b0;
      cnt_a_q     <= 2'd0;
      cnt_b_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      kv_q        <= kv_d;
      a_q         <= a_d;
      sign_a_q    <= sign_a_d;
      b_q         <= b_d;
      sign_b_q    <= sign_b_d;
      op_q        <= op_d;
      res_q       <= res_d;
      sign_r_q    <= sign_r_d;
      res_valid_q <= res_valid_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
    end
  end

  assign A         = a_q;
  assign SIGN_A    = sign_a_q;
  assign B         = b_q;
  assign SIGN_B    = sign_b_q;
  assign OP        = op_q;
  assign RES       = res_q;
  assign SIGN_R    = sign_r_q;
  assign RES_VALID = res_valid_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
module tb_calc_key_sequencer;

  localparam logic [7:0] K_SIGN  = 8'h0C;
  localparam logic [7:0] K_PLUS  = 8'h1A;
  localparam logic [7:0] K_MINUS = 8'h1E;
  localparam logic [7:0] K_ENTER = 8'h16;
  localparam logic [7:0] K_CLEAR = 8'h12;
  localparam logic [7:0] K_UNDEF = 8'h40;

  logic       CLOCK_50;
  logic       RESET_N;
  logic       KEY_VALID;
  logic [7:0] KEY_CODE;
  logic [7:0] A;
  logic       SIGN_A;
  logic [7:0] B;
  logic       SIGN_B;
  logic       OP;
  logic [7:0] RES;
  logic       SIGN_R;
  logic       RES_VALID;
  logic [1:0] STATE;

  int checks;
  int failures;

  calc_key_sequencer dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .KEY_VALID (KEY_VALID),
    .KEY_CODE  (KEY_CODE),
    .A         (A),
    .SIGN_A    (SIGN_A),
    .B         (B),
    .SIGN_B    (SIGN_B),
    .OP        (OP),
    .RES       (RES),
    .SIGN_R    (SIGN_R),
    .RES_VALID (RES_VALID),
    .STATE     (STATE)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [7:0] ea, input logic esa,
                         input logic [7:0] eb, input logic esb,
                         input logic eop, input logic [7:0] eres,
                         input logic esr, input logic erv,
                         input logic [1:0] est);
    chk({tag, ".A"},         A,                 ea);
    chk({tag, ".SIGN_A"},    {7'd0, SIGN_A},    {7'd0, esa});
    chk({tag, ".B"},         B,                 eb);
    chk({tag, ".SIGN_B"},    {7'd0, SIGN_B},    {7'd0, esb});
    chk({tag, ".OP"},        {7'd0, OP},        {7'd0, eop});
    chk({tag, ".RES"},       RES,               eres);
    chk({tag, ".SIGN_R"},    {7'd0, SIGN_R},    {7'd0, esr});
    chk({tag, ".RES_VALID"}, {7'd0, RES_VALID}, {7'd0, erv});
    chk({tag, ".STATE"},     {6'd0, STATE},     {6'd0, est});
  endtask

  // Called 1 time unit after a rising edge; returns 1 unit after the edge at
  // which the event has been taken.
  task automatic key_hi(input logic [7:0] code);
    KEY_CODE  = code;
    KEY_VALID = 1'b1;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic key_lo();
    KEY_VALID = 1'b0;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press(input logic [7:0] code);
    key_hi(code);
    key_lo();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    RESET_N   = 1'b0;
    KEY_VALID = 1'b0;
    KEY_CODE  = 8'd0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk_all("reset", 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0);
    RESET_N = 1'b1;
    @(posedge CLOCK_50);
    #1;

    // 42 + 17 = 59
    press(8'd4);
    press(8'd2);
    chk("t1.A42", A, 8'd42);
    press(K_PLUS);
    chk("t1.state_b", {6'd0, STATE}, 8'd1);
    press(8'd1);
    press(8'd7);
    key_hi(K_ENTER);
    chk_all("t1.calc", 8'd42, 1'b0, 8'd17, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd2);
    key_lo();
    chk_all("t1.show", 8'd42, 1'b0, 8'd17, 1'b0, 1'b0, 8'd59, 1'b0, 1'b1, 2'd3);
    // Operator keys and ENTER ignored in SHOW
    press(K_MINUS);
    press(K_ENTER);
    press(K_SIGN);
    chk_all("t1.show_ign", 8'd42, 1'b0, 8'd17, 1'b0, 1'b0, 8'd59, 1'b0, 1'b1, 2'd3);

    // New calculation from SHOW: 15 - 40 = -25
    press(8'd1);
    chk_all("t2.newcalc", 8'd1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0);
    press(8'd5);
    press(K_MINUS);
    press(8'd4);
    press(8'd0);
    press(K_ENTER);
    chk_all("t2.show", 8'd15, 1'b0, 8'd40, 1'b0, 1'b1, 8'd25, 1'b1, 1'b1, 2'd3);
    press(8'd3);
    chk_all("t2.digit3", 8'd3, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0);

    // -99 - (-99) = 0 with sign forced positive; third digit ignored
    press(K_CLEAR);
    press(8'd9);
    press(8'd9);
    press(8'd9);
    chk("t3.A_sat", A, 8'd99);
    press(K_SIGN);
    press(K_MINUS);
    press(8'd9);
    press(8'd9);
    press(K_SIGN);
    press(K_MINUS);
    press(K_ENTER);
    chk_all("t3.zero", 8'd99, 1'b1, 8'd99, 1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 2'd3);
    press(K_CLEAR);
    chk_all("t3.clear", 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0);
    // -99 + -99 = -198
    press(8'd9);
    press(8'd9);
    press(K_SIGN);
    press(K_PLUS);
    press(8'd9);
    press(8'd9);
    press(K_SIGN);
    press(K_ENTER);
    chk_all("t3.max", 8'd99, 1'b1, 8'd99, 1'b1, 1'b0, 8'd198, 1'b1, 1'b1, 2'd3);

    // KEY_VALID held high for 1000 cycles gives a single event
    press(K_CLEAR);
    KEY_CODE  = 8'd5;
    KEY_VALID = 1'b1;
    repeat (1000) @(posedge CLOCK_50);
    #1;
    chk("t4.held", A, 8'd5);
    key_lo();
    press(8'd5);
    chk("t4.again", A, 8'd55);

    // Asynchronous reset mid-cycle while in ENTRY_B with A=12, B=3
    press(K_CLEAR);
    press(8'd1);
    press(8'd2);
    press(K_PLUS);
    press(8'd3);
    chk_all("t5.pre", 8'd12, 1'b0, 8'd3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd1);
    @(posedge CLOCK_50);
    #5;
    RESET_N = 1'b0;
    #1;
    chk_all("t5.async", 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0);
    #2;
    RESET_N = 1'b1;
    @(posedge CLOCK_50);
    #1;

    // CLEAR straight after a calculation; an event cannot fall in the CALC
    // cycle itself because KEY_VALID was high at the ENTER edge.
    press(8'd8);
    press(K_MINUS);
    press(8'd2);
    key_hi(K_ENTER);
    chk("t6.calc_rv", {7'd0, RES_VALID}, 8'd0);
    chk("t6.calc_st", {6'd0, STATE}, 8'd2);
    key_lo();
    chk("t6.res", RES, 8'd6);
    press(K_CLEAR);
    chk_all("t6.clear", 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0);

    // Undefined code and ENTER-in-ENTRY_A change nothing
    press(8'd1);
    press(K_UNDEF);
    press(K_ENTER);
    chk_all("t7.undef_a", 8'd1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0);
    press(K_MINUS);
    press(8'd2);
    press(K_UNDEF);
    chk_all("t7.undef_b", 8'd1, 1'b0, 8'd2, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 2'd1);
    press(K_ENTER);
    press(K_UNDEF);
    chk_all("t7.undef_show", 8'd1, 1'b0, 8'd2, 1'b0, 1'b1, 8'd1, 1'b1, 1'b1, 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
